// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared geometry defaults, FSM state encoding and the
// saturating-counter helper for the direct-mapped write-through data cache.
package data_cache_pkg;

  localparam int DC_WORD_W        = 16;
  localparam int DC_LINES         = 8;
  localparam int DC_LINE_WORDS    = 4;
  localparam int DC_MEM_RD_CYCLES = 3;
  localparam int CNT_W            = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } dc_state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU data port plus memory data-side bus of the cache.
//   master : the environment (CPU drives requests, memory drives mem_rdata)
//   slave  : the cache (answers the CPU, drives the memory request lines)
// Signals: cpu_read/cpu_write/cpu_addr/cpu_wdata -> cache, cpu_rdata/cpu_ready
// <- cache; mem_read/mem_write/mem_addr/mem_wdata <- cache, mem_rdata -> cache.
interface data_cache_if #(
  parameter int WORD_W = 16
);
  logic              cpu_read;
  logic              cpu_write;
  logic [WORD_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_line_store.sv
// data_cache_line_store: flop-based valid/tag/data arrays of the cache.
// One combinational read port (index + word offset) and one write port that
// can update a single data word and/or the line metadata (valid + tag) at the
// same edge. Only the valid bits are reset; tags/data are qualified by valid.
module data_cache_line_store #(
  parameter  int WORD_W     = 16,
  parameter  int LINES      = 8,
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = $clog2(LINES),
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int TAG_W      = WORD_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset_n,
  // read port
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_word,
  // write port
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_word_en,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              wr_meta_en,
  input  logic              wr_valid,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [LINES-1:0]                              valid_q;
  logic [LINES-1:0][TAG_W-1:0]                   tag_q;
  logic [LINES-1:0][LINE_WORDS-1:0][WORD_W-1:0]  data_q;

  always_ff @(posedge clk) begin
    if (!reset_n)        valid_q         <= '0;
    else if (wr_meta_en) valid_q[wr_idx] <= wr_valid;
  end

  always_ff @(posedge clk) begin
    if (wr_meta_en) tag_q[wr_idx]          <= wr_tag;
    if (wr_word_en) data_q[wr_idx][wr_off] <= wr_word;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   clk, reset_n    : clock, synchronous active-low reset
//   bus (slave)     : CPU request/response and memory data-side lines
//   hit_count       : read hits (saturating); the refill-completing read is
//                     not counted as a hit
//   miss_count      : read misses (saturating), bumped once per fill
// Read hits and all writes complete combinationally in the request cycle.
// A read miss stalls the CPU while the line is fetched word by word, each
// word with mem_read held MEM_RD_CYCLES cycles and sampled on the last one.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int WORD_W        = DC_WORD_W,
  parameter int LINES         = DC_LINES,
  parameter int LINE_WORDS    = DC_LINE_WORDS,
  parameter int MEM_RD_CYCLES = DC_MEM_RD_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  data_cache_if.slave      bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int TAG_W  = WORD_W - IDX_W - OFF_W;
  localparam int WAIT_W = $clog2(MEM_RD_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_RD_CYCLES - 1);

  dc_state_e         state_q, state_d;
  logic [OFF_W-1:0]  word_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic              refilled_q;

  // request address fields
  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  assign req_off = bus.cpu_addr[OFF_W-1:0];
  assign req_idx = bus.cpu_addr[OFF_W +: IDX_W];
  assign req_tag = bus.cpu_addr[WORD_W-1 -: TAG_W];

  // line store ports
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_word;
  logic [IDX_W-1:0]  st_idx;
  logic              st_word_en;
  logic [OFF_W-1:0]  st_off;
  logic [WORD_W-1:0] st_word;
  logic              st_meta_en;
  logic              st_valid;
  logic [TAG_W-1:0]  st_tag;

  data_cache_line_store #(
    .WORD_W     (WORD_W),
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_idx     (req_idx),
    .rd_off     (req_off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .wr_idx     (st_idx),
    .wr_word_en (st_word_en),
    .wr_off     (st_off),
    .wr_word    (st_word),
    .wr_meta_en (st_meta_en),
    .wr_valid   (st_valid),
    .wr_tag     (st_tag)
  );

  logic hit, rd_hit, rd_miss, word_done, fill_done;
  assign hit       = rd_valid && (rd_tag == req_tag);
  // a simultaneous write wins; the read half is ignored that cycle
  assign rd_hit    = (state_q == IDLE) && bus.cpu_read && !bus.cpu_write && hit;
  assign rd_miss   = (state_q == IDLE) && bus.cpu_read && !bus.cpu_write && !hit;
  assign word_done = (state_q == FILL) && (wait_cnt_q == WAIT_LAST);
  assign fill_done = word_done && (word_cnt_q == '1);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    st_idx        = req_idx;
    st_word_en    = 1'b0;
    st_off        = req_off;
    st_word       = bus.cpu_wdata;
    st_meta_en    = 1'b0;
    st_valid      = 1'b0;
    st_tag        = req_tag;
    case (state_q)
      IDLE: begin
        if (bus.cpu_write) begin
          // write-through: memory always sees the store; cache only on a hit
          bus.cpu_ready = 1'b1;
          bus.mem_write = 1'b1;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
          st_word_en    = hit;
        end else if (bus.cpu_read) begin
          if (hit) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_rdata = rd_word;
          end else begin
            // drop the victim line now so a partial fill is never visible
            state_d    = FILL;
            st_meta_en = 1'b1;
            st_valid   = 1'b0;
          end
        end
      end
      FILL: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {fill_tag_q, fill_idx_q, word_cnt_q};
        st_idx       = fill_idx_q;
        st_off       = word_cnt_q;
        st_word      = bus.mem_rdata;
        st_word_en   = word_done;
        if (fill_done) begin
          st_meta_en = 1'b1;
          st_valid   = 1'b1;
          st_tag     = fill_tag_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // fill sequencing, refill bookkeeping and statistics
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      refilled_q <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_miss) begin
        fill_tag_q <= req_tag;
        fill_idx_q <= req_idx;
        word_cnt_q <= '0;
        wait_cnt_q <= '0;
        miss_count <= sat_inc(miss_count);
      end
      if (state_q == FILL) begin
        if (word_done) begin
          wait_cnt_q <= '0;
          word_cnt_q <= word_cnt_q + 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end
      // the held read that completes a refill is already counted as a miss
      if (fill_done) begin
        refilled_q <= 1'b1;
      end else if (rd_hit) begin
        if (refilled_q) refilled_q <= 1'b0;
        else            hit_count  <= sat_inc(hit_count);
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache. A transaction-level
// reference (reference memory image + resident-line table + hit/miss tallies)
// produces per-cycle expectations; one negedge process compares them.
module tb_data_cache;

  localparam int FILL_CYC = 12;  // 4 words x 3 cycles

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] hit_count, miss_count;

  data_cache_if #(.WORD_W(16)) bus ();

  data_cache #(
    .WORD_W(16), .LINES(8), .LINE_WORDS(4), .MEM_RD_CYCLES(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // ---------------- memory device ----------------
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [1:0]  mcnt;

  always @(posedge clk) begin
    if (!reset_n || !bus.mem_read || mcnt == 2'd2) mcnt <= 2'd0;
    else                                           mcnt <= mcnt + 2'd1;
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  // data only valid on the last cycle of each word access
  assign bus.mem_rdata = (bus.mem_read && mcnt == 2'd2) ? mem[bus.mem_addr] : 16'hDEAD;

  // activity tallies used by literal checks
  int mrd_cycles = 0, mwr_cycles = 0;
  always @(negedge clk) begin
    if (bus.mem_read)  mrd_cycles <= mrd_cycles + 1;
    if (bus.mem_write) mwr_cycles <= mwr_cycles + 1;
  end

  // ---------------- reference model state ----------------
  bit          mv [0:7];
  logic [10:0] mt [0:7];
  int          m_hits, m_misses;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle expectations
  bit          exp_en = 0;
  bit          exp_ready, exp_mrd, exp_mwr, exp_rd_chk;
  logic [15:0] exp_maddr, exp_mwdata, exp_rdata;
  int          exp_hits, exp_misses;

  always @(negedge clk) begin
    if (exp_en) begin
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(exp_ready));
      chk("mem_read", 32'(bus.mem_read), 32'(exp_mrd));
      chk("mem_write", 32'(bus.mem_write), 32'(exp_mwr));
      if (exp_mrd || exp_mwr) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
      if (exp_mwr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_mwdata));
      if (exp_rd_chk) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
      chk("hit_count", 32'(hit_count), exp_hits);
      chk("miss_count", 32'(miss_count), exp_misses);
    end
  end

  task automatic set_exp_base();
    exp_en     = 1;
    exp_ready  = 0;
    exp_mrd    = 0;
    exp_mwr    = 0;
    exp_rd_chk = 0;
    exp_maddr  = '0;
    exp_mwdata = '0;
    exp_rdata  = '0;
    exp_hits   = m_hits;
    exp_misses = m_misses;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mv[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_idle();
    bus.cpu_read  = 0;
    bus.cpu_write = 0;
    set_exp_base();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] v, input bit with_read);
    bus.cpu_read  = with_read;
    bus.cpu_write = 1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = v;
    set_exp_base();
    exp_ready  = 1;
    exp_mwr    = 1;
    exp_maddr  = a;
    exp_mwdata = v;
    @(negedge clk);
    next_cycle();
    bus.cpu_read  = 0;
    bus.cpu_write = 0;
    ref_mem[a] = v;
  endtask

  // rst_at >= 0 pulses reset in that cycle of a miss (fill abort); lat = -2 then
  task automatic do_read(input logic [15:0] a, input int rst_at,
                         output int lat, output logic [15:0] d);
    bit          hit, done;
    logic [15:0] base;
    hit  = mv[a[4:2]] && (mt[a[4:2]] == a[15:5]);
    base = {a[15:2], 2'b00};
    lat  = -1;
    d    = '0;
    bus.cpu_read  = 1;
    bus.cpu_write = 0;
    bus.cpu_addr  = a;
    bus.cpu_wdata = 16'($urandom);
    for (int k = 0; k < 40; k++) begin
      set_exp_base();
      if (hit) begin
        exp_ready = (k == 0);
        if (k > 0) exp_en = 0;
      end else begin
        exp_ready  = (k == FILL_CYC + 1);
        exp_mrd    = (k >= 1) && (k <= FILL_CYC);
        if (exp_mrd) exp_maddr = base + 16'((k - 1) / 3);
        if (k >= 1) exp_misses = m_misses + 1;
        if (k > FILL_CYC + 1) exp_en = 0;
      end
      if (exp_ready) begin
        exp_rd_chk = 1;
        exp_rdata  = ref_mem[a];
      end
      if (k == rst_at) begin
        reset_n      = 0;
        bus.cpu_read = 0;
      end
      @(negedge clk);
      done = bus.cpu_ready && (k != rst_at);
      if (done) begin
        lat = k;
        d   = bus.cpu_rdata;
      end
      next_cycle();
      if (k == rst_at) begin
        reset_n = 1;
        exp_en  = 0;
        model_reset();
        lat = -2;
        return;
      end
      if (done) break;
    end
    bus.cpu_read = 0;
    exp_en = 0;
    if (lat < 0) chk("read_completes", 32'd0, 32'd1);
    if (hit) m_hits++;
    else begin
      m_misses++;
      mv[a[4:2]] = 1;
      mt[a[4:2]] = a[15:5];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat, mrd0, mwr0, op;
    logic [15:0] d, a;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, mrd0, mwr0, op;
    logic [15:0] d, a;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0024] = 16'hF01C; ref_mem[16'h0024] = 16'hF01C;
    mem[16'h0025] = 16'h6100; ref_mem[16'h0025] = 16'h6100;
    mem[16'h0027] = 16'h6200; ref_mem[16'h0027] = 16'h6200;
    mem[16'h0044] = 16'hFC1C; ref_mem[16'h0044] = 16'hFC1C;

    model_reset();
    reset_n       = 0;
    bus.cpu_read  = 0;
    bus.cpu_write = 0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (2) next_cycle();
    reset_n = 1;

    // reset state
    @(negedge clk);
    chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    next_cycle();

    // cold miss
    mrd0 = mrd_cycles;
    do_read(16'h0024, -1, lat, d);
    chk("cold_latency", 32'(lat), 32'd13);
    chk("cold_data", 32'(d), 32'hF01C);
    chk("cold_mem_read_cycles", 32'(mrd_cycles - mrd0), 32'd12);
    chk("cold_misses", 32'(miss_count), 32'd1);
    chk("cold_hits", 32'(hit_count), 32'd0);

    // hits in the same line
    do_read(16'h0025, -1, lat, d);
    chk("hit25_latency", 32'(lat), 32'd0);
    chk("hit25_data", 32'(d), 32'h6100);
    do_read(16'h0027, -1, lat, d);
    chk("hit27_data", 32'(d), 32'h6200);
    chk("two_hits", 32'(hit_count), 32'd2);

    // conflict on index 1
    do_read(16'h0044, -1, lat, d);
    chk("conf44_latency", 32'(lat), 32'd13);
    chk("conf44_data", 32'(d), 32'hFC1C);
    do_read(16'h0024, -1, lat, d);
    chk("re24_latency", 32'(lat), 32'd13);
    chk("three_misses", 32'(miss_count), 32'd3);

    // write hit
    mwr0 = mwr_cycles;
    do_write(16'h0026, 16'hBEEF, 1'b0);
    do_idle();
    chk("wr_hit_pulses", 32'(mwr_cycles - mwr0), 32'd1);
    do_read(16'h0026, -1, lat, d);
    chk("wr_hit_latency", 32'(lat), 32'd0);
    chk("wr_hit_data", 32'(d), 32'hBEEF);

    // write miss: no allocation
    mrd0 = mrd_cycles;
    do_write(16'h0080, 16'h1234, 1'b0);
    do_idle();
    chk("wr_miss_no_fill", 32'(mrd_cycles - mrd0), 32'd0);
    do_read(16'h0080, -1, lat, d);
    chk("wr_miss_latency", 32'(lat), 32'd13);
    chk("wr_miss_data", 32'(d), 32'h1234);

    // reset in the middle of a fill
    do_read(16'h0030, 5, lat, d);
    chk("abort_mem_read", 32'(bus.mem_read), 32'd0);
    chk("abort_hits", 32'(hit_count), 32'd0);
    chk("abort_misses", 32'(miss_count), 32'd0);
    do_read(16'h0030, -1, lat, d);
    chk("abort_reread_latency", 32'(lat), 32'd13);
    chk("abort_reread_misses", 32'(miss_count), 32'd1);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      a  = 16'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a[15:7] = 9'h1FF;
      op = $urandom_range(0, 9);
      if (op < 6)      do_read(a, -1, lat, d);
      else if (op < 9) do_write(a, 16'($urandom), 1'b0);
      else             do_write(a, 16'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) do_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
